// File: rtl/bp_pkg.sv
// Shared types and constants for the branch decision/prediction unit.
package bp_pkg;

   // 2-bit saturating predictor counter; MSB is the taken prediction
   typedef logic [1:0] ctr2_t;

   localparam ctr2_t CTR_SNT = 2'b00;
   localparam ctr2_t CTR_WNT = 2'b01;
   localparam ctr2_t CTR_ST  = 2'b11;

   // RV32I conditional branch funct3 encodings (010/011 are reserved)
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // Saturating step of a 2-bit counter: up when taken, down otherwise
   function automatic ctr2_t ctr_update(input ctr2_t c, input logic up);
      ctr2_t r;
      if (up) begin
         if (c == CTR_ST) r = CTR_ST;
         else             r = c + 2'b01;
      end else begin
         if (c == CTR_SNT) r = CTR_SNT;
         else              r = c - 2'b01;
      end
      return r;
   endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition decoder from the ALU flags of rs1 - rs2.
// carry = 1 means the subtraction produced no borrow (rs1 >= rs2 unsigned).
module branch_cond
   import bp_pkg::*;
(
   input  logic [2:0] funct3_i,
   input  logic       zero_i,
   input  logic       negative_i,
   input  logic       overflow_i,
   input  logic       carry_i,
   output logic       cond_o,
   output logic       illegal_o
);

   // Decode funct3 into a taken condition; reserved encodings flag illegal
   always_comb begin
      cond_o    = 1'b0;
      illegal_o = 1'b0;
      case (funct3_i)
         F3_BEQ:  cond_o = zero_i;
         F3_BNE:  cond_o = ~zero_i;
         F3_BLT:  cond_o = negative_i ^ overflow_i;
         F3_BGE:  cond_o = ~(negative_i ^ overflow_i);
         F3_BLTU: cond_o = ~carry_i;
         F3_BGEU: cond_o = carry_i;
         default: begin
            cond_o    = 1'b0;
            illegal_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/branch_predict_resolve.sv
// Branch decision unit: gshare/bimodal prediction in Fetch, outcome
// resolution, misprediction redirect and statistics in Execute.
// The table and history only learn from committed, legal conditional
// branches; a same-cycle update is not bypassed to the Fetch lookup.
module branch_predict_resolve
   import bp_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int IDX_W  = 6,
   parameter int HIST_W = 4,
   parameter int GSHARE = 1,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [XLEN-1:0]  PCF,
   output logic             pred_takenF,
   output logic [IDX_W-1:0] pred_idxF,
   input  logic             validE,
   input  logic             JumpE,
   input  logic             BranchE,
   input  logic [2:0]       funct3E,
   input  logic             zero,
   input  logic             negative,
   input  logic             overflow,
   input  logic             carry,
   input  logic             pred_takenE,
   input  logic [IDX_W-1:0] pred_idxE,
   output logic             takenE,
   output logic             redirectE,
   output logic             illegal_brE,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam int DEPTH = 2 ** IDX_W;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   ctr2_t             table_q [DEPTH];
   logic [HIST_W-1:0] hist_q, hist_d, hist_shift_s;
   logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0]  mispred_cnt_q, mispred_cnt_d;
   logic [IDX_W-1:0]  pc_idx_s, idx_s;
   logic              cond_s, illegal_s, update_s;
   logic              unused_s;

   // ---------------- Fetch lookup ----------------
   assign pc_idx_s = PCF[IDX_W+1:2];
   assign unused_s = ^{PCF[XLEN-1:IDX_W+2], PCF[1:0]};

   generate
      if (GSHARE != 0) begin : g_gshare
         assign idx_s = pc_idx_s ^ IDX_W'(hist_q);
      end else begin : g_bimodal
         assign idx_s = pc_idx_s;
      end
   endgenerate

   assign pred_idxF   = idx_s;
   assign pred_takenF = table_q[idx_s][1];

   // ---------------- Execute resolution ----------------
   branch_cond u_cond (
      .funct3_i   (funct3E),
      .zero_i     (zero),
      .negative_i (negative),
      .overflow_i (overflow),
      .carry_i    (carry),
      .cond_o     (cond_s),
      .illegal_o  (illegal_s)
   );

   // Resolve outcome/redirect; jumps win over branches, bubbles drive zeros
   always_comb begin
      takenE      = 1'b0;
      redirectE   = 1'b0;
      illegal_brE = 1'b0;
      if (validE) begin
         if (JumpE) begin
            takenE    = 1'b1;
            redirectE = 1'b1;
         end else if (BranchE) begin
            if (illegal_s) begin
               illegal_brE = 1'b1;
            end else begin
               takenE    = cond_s;
               redirectE = cond_s ^ pred_takenE;
            end
         end else begin
            takenE = 1'b0;
         end
      end else begin
         takenE = 1'b0;
      end
   end

   assign update_s = validE & BranchE & ~JumpE & ~illegal_s;

   generate
      if (HIST_W == 1) begin : g_hist1
         assign hist_shift_s = takenE;
      end else begin : g_histn
         assign hist_shift_s = {hist_q[HIST_W-2:0], takenE};
      end
   endgenerate

   // Next-state for history and saturating statistics counters
   always_comb begin
      hist_d        = hist_q;
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (update_s) begin
         hist_d = hist_shift_s;
         if (branch_cnt_q != CNT_MAX) branch_cnt_d = branch_cnt_q + CNT_ONE;
         else                         branch_cnt_d = branch_cnt_q;
         if (redirectE && (mispred_cnt_q != CNT_MAX)) mispred_cnt_d = mispred_cnt_q + CNT_ONE;
         else                                         mispred_cnt_d = mispred_cnt_q;
      end else begin
         hist_d = hist_q;
      end
   end

   // Predictor table: reset to weakly not-taken, train on resolved branches
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            table_q[i] <= CTR_WNT;
         end
      end else if (update_s) begin
         table_q[pred_idxE] <= ctr_update(table_q[pred_idxE], takenE);
      end
   end

   // Committed history and statistics registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q        <= {HIST_W{1'b0}};
         branch_cnt_q  <= {CNT_W{1'b0}};
         mispred_cnt_q <= {CNT_W{1'b0}};
      end else begin
         hist_q        <= hist_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign branch_cnt  = branch_cnt_q;
   assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Self-checking bench: random and directed stimulus from rs1/rs2 operands,
// checked each cycle against an operand-level behavioural model.
module tb_branch_predict_resolve;

   logic        clk, rst_n;
   logic [31:0] PCF;
   logic        validE, JumpE, BranchE;
   logic [2:0]  funct3E;
   logic        zero, negative, overflow, carry;
   logic        pred_takenE;
   logic [5:0]  pred_idxE;
   logic [31:0] op_a, op_b;

   logic        pred_takenF, takenE, redirectE, illegal_brE;
   logic [5:0]  pred_idxF;
   logic [15:0] branch_cnt, mispred_cnt;
   logic        pred_takenF4, takenE4, redirectE4, illegal_brE4;
   logic [5:0]  pred_idxF4;
   logic [3:0]  branch_cnt4, mispred_cnt4;

   int n_vec  = 0;
   int n_fail = 0;

   // Behavioural model state
   int m_tbl [64];
   int m_hist, m_bc, m_mc, m_bc4, m_mc4;

   branch_predict_resolve dut (
      .clk(clk), .rst_n(rst_n), .PCF(PCF),
      .pred_takenF(pred_takenF), .pred_idxF(pred_idxF),
      .validE(validE), .JumpE(JumpE), .BranchE(BranchE), .funct3E(funct3E),
      .zero(zero), .negative(negative), .overflow(overflow), .carry(carry),
      .pred_takenE(pred_takenE), .pred_idxE(pred_idxE),
      .takenE(takenE), .redirectE(redirectE), .illegal_brE(illegal_brE),
      .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
   );

   branch_predict_resolve #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .PCF(PCF),
      .pred_takenF(pred_takenF4), .pred_idxF(pred_idxF4),
      .validE(validE), .JumpE(JumpE), .BranchE(BranchE), .funct3E(funct3E),
      .zero(zero), .negative(negative), .overflow(overflow), .carry(carry),
      .pred_takenE(pred_takenE), .pred_idxE(pred_idxE),
      .takenE(takenE4), .redirectE(redirectE4), .illegal_brE(illegal_brE4),
      .branch_cnt(branch_cnt4), .mispred_cnt(mispred_cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 64; i++) m_tbl[i] = 1;
      m_hist = 0; m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
   endtask

   // Branch condition from the operands themselves
   function automatic bit m_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return $signed(a) <  $signed(b);
         3'd5:    return $signed(a) >= $signed(b);
         3'd6:    return a <  b;
         3'd7:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic drive(input bit v, input bit j, input bit b, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] bb,
                        input bit pt, input logic [5:0] pi, input logic [31:0] pc);
      logic [31:0] d;
      validE = v; JumpE = j; BranchE = b; funct3E = f3;
      op_a = a; op_b = bb;
      d = a - bb;
      zero     = (d == 32'd0);
      negative = d[31];
      overflow = (a[31] != bb[31]) && (d[31] != a[31]);
      carry    = (a >= bb);
      pred_takenE = pt; pred_idxE = pi; PCF = pc;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m_reset();
      tick();
      rst_n = 1'b1;
   endtask

   // Compare process: check every cycle out of reset, then advance the model
   initial begin
      int  e_idx, pidx;
      bit  legal, e_tk, e_rd, e_il, upd;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            e_idx = int'((PCF >> 2) & 32'd63) ^ m_hist;
            legal = (funct3E != 3'd2) && (funct3E != 3'd3);
            e_tk  = validE && (JumpE || (BranchE && legal && m_cond(funct3E, op_a, op_b)));
            e_rd  = validE && (JumpE || (BranchE && legal && (m_cond(funct3E, op_a, op_b) != pred_takenE)));
            e_il  = validE && !JumpE && BranchE && !legal;
            upd   = validE && !JumpE && BranchE && legal;
            chk("pred_idxF",   pred_idxF,   e_idx);
            chk("pred_takenF", pred_takenF, m_tbl[e_idx] >= 2);
            chk("takenE",      takenE,      e_tk);
            chk("redirectE",   redirectE,   e_rd);
            chk("illegal_brE", illegal_brE, e_il);
            chk("branch_cnt",  branch_cnt,  m_bc);
            chk("mispred_cnt", mispred_cnt, m_mc);
            chk("branch_cnt4", branch_cnt4, m_bc4);
            chk("mispred_cnt4",mispred_cnt4,m_mc4);
            chk("redirectE4",  redirectE4,  e_rd);
            if (upd) begin
               pidx = int'(pred_idxE);
               if (e_tk) m_tbl[pidx] = (m_tbl[pidx] == 3) ? 3 : m_tbl[pidx] + 1;
               else      m_tbl[pidx] = (m_tbl[pidx] == 0) ? 0 : m_tbl[pidx] - 1;
               m_hist = ((m_hist << 1) | (e_tk ? 1 : 0)) & 15;
               if (m_bc  < 65535) m_bc++;
               if (m_bc4 < 15)    m_bc4++;
               if (e_rd) begin
                  if (m_mc  < 65535) m_mc++;
                  if (m_mc4 < 15)    m_mc4++;
               end
            end
         end
      end
   end

   // Stimulus with hand-computed literal expectations
   initial begin
      bit          exp_rd [3];
      bit          pt_seq [3];
      int          exp_ctr [3];
      int          bad;
      logic [2:0]  sgn_f3 [4];
      bit          sgn_exp [4];
      logic [31:0] ra, rb;

      pt_seq  = '{1'b0, 1'b1, 1'b1};
      exp_rd  = '{1'b1, 1'b0, 1'b0};
      exp_ctr = '{2, 3, 3};
      sgn_f3  = '{3'd4, 3'd6, 3'd5, 3'd7};
      sgn_exp = '{1'b1, 1'b0, 1'b0, 1'b1};

      rst_n = 1'b0;
      m_reset();
      drive(0, 0, 0, 3'd0, 32'd0, 32'd0, 0, 6'd0, 32'h40);
      #2;
      chk("rst_pred_takenF", pred_takenF, 0);
      chk("rst_pred_idxF",   pred_idxF,   16);
      chk("rst_branch_cnt",  branch_cnt,  0);
      chk("rst_mispred_cnt", mispred_cnt, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Signed vs unsigned with rs1 = -1, rs2 = 1
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 1, sgn_f3[i], 32'hFFFF_FFFF, 32'd1, 0, 6'd3, 32'h0);
         #1;
         chk("signed_unsigned_takenE", takenE, sgn_exp[i]);
         tick();
      end
      // Overflow: N = 0, V = 1 still means less-than
      drive(1, 0, 1, 3'd4, 32'h8000_0000, 32'd1, 0, 6'd3, 32'h0);
      #1;
      chk("blt_overflow_flags", {negative, overflow}, 2'b01);
      chk("blt_overflow_takenE", takenE, 1);
      tick();

      // Three taken beq on entry 5 from a clean state
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 1, 3'd0, 32'd7, 32'd7, pt_seq[i], 6'd5, 32'h0);
         #1;
         chk("beq_seq_redirectE", redirectE, exp_rd[i]);
         tick();
         chk("beq_seq_entry5", dut.table_q[5], exp_ctr[i]);
      end
      drive(0, 0, 0, 3'd0, 32'd0, 32'd0, 0, 6'd0, 32'h0);
      #1;
      chk("hist_0111_idx", pred_idxF, 7);
      chk("beq_seq_mispred", mispred_cnt, 1);
      chk("beq_seq_branch",  branch_cnt,  3);
      tick();

      // Jump with branch also set: jump wins and trains nothing
      drive(1, 1, 1, 3'd0, 32'd1, 32'd2, 0, 6'd5, 32'h0);
      #1;
      chk("jump_takenE", takenE, 1);
      chk("jump_redirectE", redirectE, 1);
      tick();
      chk("jump_branch_cnt", branch_cnt, 3);
      chk("jump_hist_idx", pred_idxF, 7);
      chk("jump_entry5", dut.table_q[5], 3);
      drive(0, 1, 1, 3'd0, 32'd1, 32'd2, 0, 6'd5, 32'h0);
      #1;
      chk("bubble_outputs", {takenE, redirectE, illegal_brE}, 3'b000);
      tick();

      // Reserved funct3
      drive(1, 0, 1, 3'd2, 32'd1, 32'd1, 1, 6'd5, 32'h0);
      #1;
      chk("illegal_flag", illegal_brE, 1);
      chk("illegal_redirect", redirectE, 0);
      tick();
      chk("illegal_no_count", branch_cnt, 3);

      // Reset between an update and its clock edge
      drive(1, 0, 1, 3'd0, 32'd3, 32'd3, 0, 6'd9, 32'h0);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      m_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 64; i++) if (dut.table_q[i] !== 2'b01) bad++;
      chk("reset_mid_table_bad_entries", bad, 0);
      chk("reset_mid_branch_cnt", branch_cnt, 0);
      chk("reset_mid_mispred_cnt", mispred_cnt, 0);

      // Saturation of the 4-bit counters
      for (int i = 0; i < 17; i++) begin
         drive(1, 0, 1, 3'd0, 32'd1, 32'd1, 0, 6'($urandom_range(0, 63)), 32'h0);
         tick();
      end
      chk("sat_branch_cnt4", branch_cnt4, 15);
      chk("sat_mispred_cnt4", mispred_cnt4, 15);
      chk("sat_branch_cnt16", branch_cnt, 17);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = ra;
            1:       rb = ra ^ 32'h8000_0000;
            default: rb = $urandom;
         endcase
         drive($urandom_range(0, 99) < 85, $urandom_range(0, 9) == 0,
               $urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), ra, rb,
               $urandom_range(0, 1) == 1,
               ($urandom_range(0, 1) == 1) ? pred_idxF : 6'($urandom_range(0, 63)),
               $urandom & 32'hFFFF_FFFC);
         tick();
      end

      drive(0, 0, 0, 3'd0, 32'd0, 32'd0, 0, 6'd0, 32'h0);
      tick();
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
